// File: rtl/edgcol_pkg.sv
// Shared constants and state encoding for the edge-collision register file and its load sequencer.
package edgcol_pkg;

  localparam int unsigned EDGCOL_REG_WIDTH  = 32;
  localparam int unsigned EDGCOL_NUM_REGS   = 6;
  localparam int unsigned EDGCOL_ADDR_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_FINISH = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/edgcol_load_sequencer.sv
// Fills the edge-collision register file: six streamed words (load) or six zeros (clear),
// then pulses done once the last write has been presented to the file.
module edgcol_load_sequencer
  import edgcol_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = EDGCOL_REG_WIDTH,
  parameter int unsigned NUM_REGS   = EDGCOL_NUM_REGS,
  parameter int unsigned ADDR_WIDTH = EDGCOL_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear_req,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [REG_WIDTH-1:0]  in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic [REG_WIDTH-1:0]  wrData,
  output logic                  wrEna
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  seq_state_t            state;
  logic [ADDR_WIDTH-1:0] idx;

  // Abort masks ready in the same cycle so an aborting LOAD never consumes a word.
  assign in_ready = (state == ST_LOAD) && !abort;
  assign busy     = (state != ST_IDLE);

  // Sequencer FSM; idx saturates at LAST_IDX so the write address stays in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      wrEna  <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
      done   <= 1'b0;
    end else begin
      wrEna <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= clear_req ? ST_CLEAR : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            idx   <= '0;
            state <= ST_IDLE;
          end else if (in_valid) begin
            wrEna  <= 1'b1;
            wrAddr <= idx;
            wrData <= in_data;
            if (idx == LAST_IDX) state <= ST_FINISH;
            else                 idx   <= idx + ADDR_WIDTH'(1);
          end
        end
        ST_CLEAR: begin
          if (abort) begin
            idx   <= '0;
            state <= ST_IDLE;
          end else begin
            wrEna  <= 1'b1;
            wrAddr <= idx;
            wrData <= '0;
            if (idx == LAST_IDX) state <= ST_FINISH;
            else                 idx   <= idx + ADDR_WIDTH'(1);
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          idx   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          idx   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edgcol_load_sequencer.sv
// Directed bench for edgcol_load_sequencer: cycle vector table plus hand sequences for gaps, abort and async reset.
module tb_edgcol_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, clear_req, abort, in_valid;
  logic [31:0] in_data;
  logic        in_ready, busy, done, wrEna;
  logic [2:0]  wrAddr;
  logic [31:0] wrData;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf [6];
  int          wcnt = 0;

  edgcol_load_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .clear_req(clear_req), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .done(done), .wrAddr(wrAddr), .wrData(wrData), .wrEna(wrEna)
  );

  always #5 clk = ~clk;

  // Register-file model committing whatever the sequencer presents.
  always @(posedge clk) begin
    if (!rst && wrEna) begin
      if (wrAddr < 3'd6) rf[wrAddr] = wrData;
      wcnt = wcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wrEna) chk("addr range", 32'(wrAddr < 3'd6), 32'd1);
  end

  typedef struct {
    logic        st, clr, ab, vld;
    logic [31:0] din;
    logic        e_rdy, e_busy, e_done, e_wen;
    logic [2:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic clr, input logic vld, input logic [31:0] din,
                              input logic rdy, input logic bsy, input logic dn, input logic wen,
                              input logic [2:0] a, input logic [31:0] d);
    vec_t v;
    v.st = st; v.clr = clr; v.ab = 1'b0; v.vld = vld; v.din = din;
    v.e_rdy = rdy; v.e_busy = bsy; v.e_done = dn; v.e_wen = wen; v.e_addr = a; v.e_data = d;
    return v;
  endfunction

  task automatic idle_inputs();
    start = 0; clear_req = 0; abort = 0; in_valid = 0; in_data = '0;
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic bsy, input logic dn,
                          input logic wen, input logic [2:0] a, input logic [31:0] d);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, " busy"},     32'(busy),     32'(bsy));
    chk({tag, " done"},     32'(done),     32'(dn));
    chk({tag, " wrEna"},    32'(wrEna),    32'(wen));
    if (wen) begin
      chk({tag, " wrAddr"}, 32'(wrAddr), 32'(a));
      chk({tag, " wrData"}, wrData, d);
    end
  endtask

  // Streams six words back to back and waits (bounded) for done.
  task automatic run_load(input logic [31:0] base);
    logic got;
    @(negedge clk); start = 1; clear_req = 0;
    @(negedge clk); start = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; in_data = base + 32'(k);
      @(negedge clk);
    end
    in_valid = 0;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      #1;
      if (done) got = 1;
      else @(negedge clk);
    end
    chk("load done seen", 32'(got), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) chk($sformatf("load rf%0d", i), rf[i], base + 32'(i));
  endtask

  vec_t tbl [19];

  initial begin
    int wsnap;
    idle_inputs();
    rst = 1;
    #1;
    chk("reset in_ready", 32'(in_ready), 0);
    chk("reset busy",     32'(busy),     0);
    chk("reset done",     32'(done),     0);
    chk("reset wrEna",    32'(wrEna),    0);
    chk("reset wrAddr",   32'(wrAddr),   0);
    chk("reset wrData",   wrData,        0);
    @(negedge clk); rst = 0;

    // Full load with start pulses in LOAD and DONE, then back-to-back clear.
    tbl[0]  = mk(1, 0, 0, 0,      0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 10,     1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 20,     1, 1, 0, 1, 0, 10);
    tbl[3]  = mk(1, 1, 1, 30,     1, 1, 0, 1, 1, 20);
    tbl[4]  = mk(0, 0, 1, 40,     1, 1, 0, 1, 2, 30);
    tbl[5]  = mk(0, 0, 1, 50,     1, 1, 0, 1, 3, 40);
    tbl[6]  = mk(0, 0, 1, 60,     1, 1, 0, 1, 4, 50);
    tbl[7]  = mk(0, 0, 0, 0,      0, 1, 0, 1, 5, 60);
    tbl[8]  = mk(1, 0, 0, 0,      0, 1, 1, 0, 5, 60);
    tbl[9]  = mk(1, 1, 1, 32'hBAD, 0, 0, 0, 0, 5, 60);
    tbl[10] = mk(0, 0, 1, 32'hBAD, 0, 1, 0, 0, 5, 60);
    for (int i = 0; i < 6; i++)
      tbl[11+i] = mk(0, 0, 0, 0,  0, 1, 0, 1, 3'(i), 0);
    tbl[17] = mk(0, 0, 0, 0,      0, 1, 1, 0, 5, 0);
    tbl[18] = mk(0, 0, 0, 0,      0, 0, 0, 0, 5, 0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      start = tbl[i].st; clear_req = tbl[i].clr; abort = tbl[i].ab;
      in_valid = tbl[i].vld; in_data = tbl[i].din;
      #1;
      chk_outs($sformatf("row%0d", i), tbl[i].e_rdy, tbl[i].e_busy, tbl[i].e_done,
               tbl[i].e_wen, tbl[i].e_addr, tbl[i].e_data);
    end
    @(negedge clk); idle_inputs();
    for (int i = 0; i < 6; i++) chk($sformatf("clear rf%0d", i), rf[i], 0);

    // Load with valid on alternate cycles.
    start = 1;
    @(negedge clk); start = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 0; #1;
      chk($sformatf("gap%0d idle wrEna", k), 32'(wrEna), 32'(k > 0));
      if (k > 0) chk($sformatf("gap%0d wrAddr", k), 32'(wrAddr), 32'(k - 1));
      @(negedge clk);
      in_valid = 1; in_data = 32'(100 + k); #1;
      chk($sformatf("gap%0d in_ready", k), 32'(in_ready), 1);
      chk($sformatf("gap%0d hs wrEna", k), 32'(wrEna), 0);
      @(negedge clk);
    end
    in_valid = 0; #1;
    chk_outs("gap finish", 0, 1, 0, 1, 5, 105);
    @(negedge clk); #1;
    chk_outs("gap done", 0, 1, 1, 0, 5, 105);
    @(negedge clk); #1;
    chk_outs("gap idle", 0, 0, 0, 0, 5, 105);
    for (int i = 0; i < 6; i++) chk($sformatf("gap rf%0d", i), rf[i], 32'(100 + i));

    // Abort after three words, with a fourth word offered in the abort cycle.
    @(negedge clk); start = 1; clear_req = 0;
    @(negedge clk); start = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_data = 32'(7 + k);
      @(negedge clk);
    end
    abort = 1; in_valid = 1; in_data = 32'hDEAD; #1;
    chk_outs("abort cycle", 0, 1, 0, 1, 2, 9);
    @(negedge clk); abort = 0; in_valid = 0; #1;
    chk_outs("abort after", 0, 0, 0, 0, 2, 9);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); #1;
      chk($sformatf("abort no done%0d", n), 32'(done), 0);
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("abort rf%0d", i), rf[i], (i < 3) ? 32'(7 + i) : 32'(100 + i));

    // Asynchronous reset in the middle of a clear.
    @(negedge clk); start = 1; clear_req = 1;
    @(negedge clk); start = 0; clear_req = 0;
    @(negedge clk);
    @(negedge clk);
    #2;
    wsnap = wcnt;
    rst = 1; #1;
    chk_outs("rst mid", 0, 0, 0, 0, 0, 0);
    chk("rst wrAddr", 32'(wrAddr), 0);
    chk("rst wrData", wrData, 0);
    @(negedge clk); rst = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst no writes", 32'(wcnt), 32'(wsnap));
    chk("rst idle busy", 32'(busy), 0);
    run_load(32'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
